// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    localparam int                ADDR_W  = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {IDLE, RUN, TRAP} fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// Fetch bus: memory read port plus the valid/ready instruction handoff to decode.
interface fetch_if import fetch_pkg::*; #(parameter int WIDTH = 32) ();
    logic              mem_r_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [WIDTH-1:0]  inst;
    logic [ADDR_W-1:0] inst_pc;

    modport master (output mem_r_enable, mem_addr, inst_valid, inst, inst_pc,
                    input  mem_data, inst_ready);
    modport slave  (input  mem_r_enable, mem_addr, inst_valid, inst, inst_pc,
                    output mem_data, inst_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {word, pc} pairs; flush empties it in one cycle.
module fetch_fifo import fetch_pkg::*; #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  push_data,
    input  logic [ADDR_W-1:0] push_pc,
    output logic [WIDTH-1:0]  head_data,
    output logic [ADDR_W-1:0] head_pc,
    output logic [CNT_W-1:0]  count
);
    logic [DEPTH-1:0][WIDTH-1:0]  data_q;
    logic [DEPTH-1:0][ADDR_W-1:0] pc_q;
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= push_data;
            pc_q[wr_ptr]   <= push_pc;
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_pc   = pc_q[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC/FSM, one read per cycle, buffered handoff to decode, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect parks the unit in TRAP with fetch_misalign/misalign_pc.
module fetch_unit import fetch_pkg::*; #(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                FIFO_DEPTH = 2,
    parameter int                WIDTH      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic              fetch_misalign,
    output logic [ADDR_W-1:0] misalign_pc,
`endif
    fetch_if.master           bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, req_pc_q;
    logic              inflight_q;
    logic              issue, push, pop, misaligned;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occ;
    logic [WIDTH-1:0]  head_data;
    logic [ADDR_W-1:0] head_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lsb;
    assign misaligned          = 1'b0;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    // An outstanding read reserves a slot so its response can always be accepted.
    assign occ = {1'b0, count} + (CNT_W+1)'(inflight_q);

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE:    if (fetch_en)  state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            TRAP:    state_d = TRAP;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            if (misaligned)           state_d = TRAP;
            else if (state_q == TRAP) state_d = fetch_en ? RUN : IDLE;
        end
        if (state_q == RUN && !redirect_valid && !rst && occ < (CNT_W+1)'(FIFO_DEPTH))
            issue = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (redirect_valid) begin
                pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (issue) begin
                pc_q     <= pc_q + PC_STEP;
                req_pc_q <= pc_q;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_misalign <= 1'b0;
            misalign_pc    <= '0;
        end else if (redirect_valid) begin
            fetch_misalign <= misaligned;
            misalign_pc    <= misaligned ? redirect_pc : '0;
        end
    end
`endif

    // Redirect kills the in-flight response and voids any handshake this cycle.
    assign push = inflight_q && !redirect_valid;
    assign pop  = bus.inst_valid && bus.inst_ready && !redirect_valid;

    fetch_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data (bus.mem_data),
        .push_pc   (req_pc_q),
        .head_data (head_data),
        .head_pc   (head_pc),
        .count     (count)
    );

    assign bus.mem_r_enable = issue;
    assign bus.mem_addr     = {2'b00, pc_q[ADDR_W-1:2]};
    assign bus.inst_valid   = (count != '0);
    assign bus.inst         = bus.inst_valid ? head_data : '0;
    assign bus.inst_pc      = bus.inst_valid ? head_pc   : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC streams queued at each (re)start, popped by a monitor.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
    logic [31:0] misalign_pc;
`endif

    always #5 clk = ~clk;

    fetch_if #(.WIDTH(32)) bus ();

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_misalign (fetch_misalign),
        .misalign_pc    (misalign_pc),
`endif
        .bus            (bus)
    );

    int          checks = 0, failures = 0, reads = 0, pops = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Program order from a fetch target: consecutive words, wrapping mod 2^32.
    task automatic expect_from(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(i) * 32'd4);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wait_pop(input string name);
        int p0 = pops;
        int k  = 0;
        while (pops == p0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(pops > p0), 32'd1);
    endtask

    // Memory model: returns the word index one cycle after the request.
    always @(posedge clk) begin
        if (bus.mem_r_enable) begin
            reads        <= reads + 1;
            bus.mem_data <= bus.mem_addr;
        end
    end

    always @(negedge clk) begin
        if (!rst && !redirect_valid && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=%h required=none", bus.inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("inst_pc", bus.inst_pc, mon_e);
                chk("inst", bus.inst, mon_e >> 2);
            end
            pops++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, r_red, p_red, nv, since;
        logic [31:0] t;
        bus.inst_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_inst_valid", 32'(bus.inst_valid), 0);
        chk("rst_mem_r_enable", 32'(bus.mem_r_enable), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_inst_pc", bus.inst_pc, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_misalign", 32'(fetch_misalign), 0);
        chk("rst_misalign_pc", misalign_pc, 0);
`endif

        // First-fetch latency
        cyc(); fetch_en = 1'b1; expect_from(32'h0);
        @(negedge clk); chk("idle_no_read", 32'(bus.mem_r_enable), 0);
        cyc();
        @(negedge clk);
        chk("first_req", 32'(bus.mem_r_enable), 1);
        chk("first_addr", bus.mem_addr, 0);
        chk("lat_n", 32'(bus.inst_valid), 0);
        @(negedge clk); chk("lat_n1", 32'(bus.inst_valid), 0);
        @(negedge clk); chk("lat_n2", 32'(bus.inst_valid), 1);
        repeat (20) cyc();

        // Back-pressure: FIFO fills, reads stop, pc holds
        bus.inst_ready = 1'b0;
        repeat (5) @(negedge clk);
        r0 = reads;
        repeat (5) @(negedge clk);
        chk("stall_valid", 32'(bus.inst_valid), 1);
        chk("stall_no_req", 32'(bus.mem_r_enable), 0);
        chk("stall_reads", 32'(reads - r0), 0);
        chk("stall_head_pc", bus.inst_pc, exp_q[0]);
        chk("stall_mem_addr", bus.mem_addr, (exp_q[0] + 32'd8) >> 2);
        cyc(); bus.inst_ready = 1'b1;
        repeat (10) cyc();

        // Redirect with full FIFO, then with a read in flight
        bus.inst_ready = 1'b0;
        repeat (5) cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h40; bus.inst_ready = 1'b1; expect_from(32'h40);
        cyc(); redirect_valid = 1'b0;
        @(negedge clk); chk("flush_empty", 32'(bus.inst_valid), 0);
        wait_pop("redirect_resume");
        repeat (3) cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h100; expect_from(32'h100);
        cyc(); redirect_valid = 1'b0;
        wait_pop("redirect_inflight_resume");

        // PC wrap, then fetch_en drop mid-stream
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; expect_from(32'hFFFF_FFF8);
        r_red = reads; p_red = pops;
        cyc(); redirect_valid = 1'b0;
        repeat (12) cyc();
        chk("wrap_pops", 32'((pops - p_red) >= 3), 1);
        fetch_en = 1'b0;
        cyc();
        @(negedge clk); r1 = reads;
        repeat (6) cyc();
        @(negedge clk);
        chk("idle_no_reads", 32'(reads - r1), 0);
        chk("idle_no_req", 32'(bus.mem_r_enable), 0);
        chk("inflight_delivered", 32'(pops - p_red), 32'(reads - r_red));
        chk("idle_drained", 32'(bus.inst_valid), 0);

        // Reset mid-operation
        cyc(); fetch_en = 1'b1;
        repeat (4) cyc();
        bus.inst_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b1; exp_q.delete();
        cyc(); rst = 1'b0; fetch_en = 1'b0; bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_inst_valid", 32'(bus.inst_valid), 0);
        chk("mid_rst_mem_addr", bus.mem_addr, 0);
        chk("mid_rst_mem_r_enable", 32'(bus.mem_r_enable), 0);
        nv = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.inst_valid) nv++;
        end
        chk("no_late_push", 32'(nv), 0);

        // Randomized traffic
        cyc(); expect_from(32'h0); fetch_en = 1'b1;
        since = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            redirect_valid = 1'b0;
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            since++;
            if ($urandom_range(0, 99) < 5 || since >= 80) begin
                t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
                t = t & ~32'h3;
`endif
                redirect_valid = 1'b1; redirect_pc = t; expect_from(t & ~32'h3);
                since = 0;
            end else if ($urandom_range(0, 99) < 4) begin
                fetch_en = ~fetch_en;
            end
        end
        cyc(); redirect_valid = 1'b0; fetch_en = 1'b1; bus.inst_ready = 1'b1;
        wait_pop("rand_progress");

`ifdef FETCH_MISALIGN_TRAP_EN
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h42; exp_q.delete();
        cyc(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("trap_flag", 32'(fetch_misalign), 1);
        chk("trap_pc", misalign_pc, 32'h42);
        chk("trap_empty", 32'(bus.inst_valid), 0);
        r0 = reads;
        repeat (5) cyc();
        chk("trap_no_reads", 32'(reads - r0), 0);
        chk("trap_held", 32'(fetch_misalign), 1);
        redirect_valid = 1'b1; redirect_pc = 32'h80; expect_from(32'h80);
        cyc(); redirect_valid = 1'b0;
        @(negedge clk); chk("trap_cleared", 32'(fetch_misalign), 0);
        wait_pop("trap_resume");
`endif

        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
